// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between the bridge (master) and a register-file completer (slave).
// Handshake: a transfer is a setup cycle (psel=1, penable=0) followed by access cycles
// (psel=1, penable=1); it completes in the one cycle where pready=1, and pr_data/pslverr
// are meaningful only in that cycle. Master holds paddr/pwrite/pwdata stable meanwhile.
interface apb_slave_regfile_if;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] pr_data;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pr_data, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pr_data, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB completer with a bank of 32-bit registers, programmable wait states and
// pslverr on out-of-range or misaligned accesses. All outputs are registered.
module apb_slave_regfile #(
  parameter int          SLV_IDX     = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] RESET_VAL   = 32'h0
) (
  input  logic                hclk,
  input  logic                hreset,
  apb_slave_regfile_if.slave  apb,
  output logic                dbg_state
);

  localparam int          IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [31:0] SPAN  = 32'(NUM_REGS * 4);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               write_q, write_d;
  logic               legal_q, legal_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               pready_q, pready_d;
  logic               pslverr_q, pslverr_d;
  logic [31:0]        pr_data_q, pr_data_d;
  logic [31:0]        regs_q [NUM_REGS];
  logic [31:0]        regs_d [NUM_REGS];

  logic               sel;
  logic [31:0]        offset;
  logic               dec_legal;
  logic [IDX_W-1:0]   dec_idx;
  logic [IDX_W-1:0]   rd_idx;
  logic [31:0]        rd_word;

  assign sel       = apb.psel[SLV_IDX];
  assign offset    = apb.paddr - BASE_ADDR;
  assign dec_legal = (apb.paddr >= BASE_ADDR) && (offset < SPAN) && (apb.paddr[1:0] == 2'b00);
  assign dec_idx   = offset[IDX_W+1:2];

  // With zero wait states the response is built from the live decode at setup.
  assign rd_idx  = (state_q == IDLE) ? dec_idx : idx_q;
  assign rd_word = regs_q[rd_idx];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    legal_d   = legal_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    pr_data_d = pr_data_q;
    regs_d    = regs_q;

    case (state_q)
      IDLE: begin
        if (sel && !apb.penable) begin
          state_d = ACCESS;
          write_d = apb.pwrite;
          legal_d = dec_legal;
          idx_d   = dec_idx;
          wdata_d = apb.pwdata;
          cnt_d   = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            pready_d  = 1'b1;
            pslverr_d = !dec_legal;
            pr_data_d = (dec_legal && !apb.pwrite) ? rd_word : 32'h0;
          end
        end
      end
      ACCESS: begin
        if (pready_q) begin
          if (legal_q && write_q) regs_d[idx_q] = wdata_q;
          state_d   = IDLE;
          cnt_d     = 4'h0;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          pr_data_d = 32'h0;
        end else if (!sel || !apb.penable) begin
          state_d = IDLE;
          cnt_d   = 4'h0;
        end else if (cnt_q <= 4'd1) begin
          cnt_d     = 4'h0;
          pready_d  = 1'b1;
          pslverr_d = !legal_q;
          pr_data_d = (legal_q && !write_q) ? rd_word : 32'h0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'h0;
      write_q   <= 1'b0;
      legal_q   <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= 32'h0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      pr_data_q <= 32'h0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      write_q   <= write_d;
      legal_q   <= legal_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      pr_data_q <= pr_data_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign apb.pr_data = pr_data_q;
  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;
  assign dbg_state   = (state_q == ACCESS);

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: one instance with two wait states, one with none.
module tb_apb_slave_regfile;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic hclk = 1'b0;
  logic hreset;
  logic dbg_a, dbg_b;

  always #5 hclk = ~hclk;

  apb_slave_regfile_if if_a ();
  apb_slave_regfile_if if_b ();

  apb_slave_regfile #(.SLV_IDX(0), .BASE_ADDR(BASE), .NUM_REGS(16), .WAIT_CYCLES(2),
                      .RESET_VAL(32'h0)) dut_a (
    .hclk(hclk), .hreset(hreset), .apb(if_a.slave), .dbg_state(dbg_a));

  apb_slave_regfile #(.SLV_IDX(0), .BASE_ADDR(BASE), .NUM_REGS(16), .WAIT_CYCLES(0),
                      .RESET_VAL(32'h0)) dut_b (
    .hclk(hclk), .hreset(hreset), .apb(if_b.slave), .dbg_state(dbg_b));

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] model [16];
  logic [31:0] exp_q [$];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input bit b, input logic [2:0] ps, input logic en, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (b) begin
      if_b.psel = ps; if_b.penable = en; if_b.pwrite = wr; if_b.paddr = a; if_b.pwdata = d;
    end else begin
      if_a.psel = ps; if_a.penable = en; if_a.pwrite = wr; if_a.paddr = a; if_a.pwdata = d;
    end
  endtask

  task automatic sample(input bit b, output logic rdy, output logic err, output logic [31:0] rd);
    if (b) begin
      rdy = if_b.pready; err = if_b.pslverr; rd = if_b.pr_data;
    end else begin
      rdy = if_a.pready; err = if_a.pslverr; rd = if_a.pr_data;
    end
  endtask

  task automatic bus_idle(input bit b);
    @(posedge hclk); #1;
    drive(b, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Full transfer; returns on the negedge of the completion cycle (lat counts from T1).
  task automatic xfer(input bit b, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic err, output int lat);
    logic rdy;
    @(posedge hclk); #1;
    drive(b, 3'b001, 1'b0, wr, a, d);
    @(posedge hclk); #1;
    drive(b, 3'b001, 1'b1, wr, a, d);
    lat = 0;
    rdy = 1'b0;
    rd  = 32'h0;
    err = 1'b0;
    while (!rdy && lat < 16) begin
      @(negedge hclk);
      lat++;
      sample(b, rdy, err, rd);
      if (!rdy) @(posedge hclk);
    end
  endtask

  task automatic check_outputs_zero(input bit b, input string name);
    logic rdy, err;
    logic [31:0] rd;
    sample(b, rdy, err, rd);
    check({name, " pready"}, {31'h0, rdy}, 32'h0);
    check({name, " pslverr"}, {31'h0, err}, 32'h0);
    check({name, " pr_data"}, rd, 32'h0);
    check({name, " state"}, {31'h0, (b ? dbg_b : dbg_a)}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;
    logic        rdy;

    vecs[0]  = '{1'b1, BASE + 32'h08, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, BASE + 32'h08, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, BASE + 32'h40, 32'h5555_5555, 1'b1, 32'h0};
    vecs[3]  = '{1'b1, BASE + 32'h06, 32'h6666_6666, 1'b1, 32'h0};
    vecs[4]  = '{1'b1, BASE + 32'h3C, 32'h0F0F_0001, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, BASE + 32'h00, 32'h0000_0001, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, BASE + 32'h3C, 32'h0,         1'b0, 32'h0F0F_0001};
    vecs[7]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         1'b1, 32'h0};
    vecs[8]  = '{1'b0, BASE + 32'h41, 32'h0,         1'b1, 32'h0};
    vecs[9]  = '{1'b0, BASE + 32'h04, 32'h0,         1'b0, 32'h0};
    vecs[10] = '{1'b0, BASE + 32'h00, 32'h0,         1'b0, 32'h0000_0001};
    for (int i = 0; i < 16; i++) model[i] = 32'h0;

    // Clock/reset
    hreset = 1'b1;
    drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    check_outputs_zero(1'b0, "reset_a");
    check_outputs_zero(1'b1, "reset_b");
    hreset = 1'b0;

    // Reset during the wait phase of a write aborts it
    @(posedge hclk); #1;
    drive(1'b0, 3'b001, 1'b0, 1'b1, BASE + 32'h04, 32'hA5A5_A5A5);
    @(posedge hclk); #1;
    drive(1'b0, 3'b001, 1'b1, 1'b1, BASE + 32'h04, 32'hA5A5_A5A5);
    @(negedge hclk);
    check("t1 in_access", {31'h0, dbg_a}, 32'h1);
    @(negedge hclk);
    hreset = 1'b1;
    #1;
    check_outputs_zero(1'b0, "t1 async_reset");
    drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge hclk);
    hreset = 1'b0;
    xfer(1'b0, 1'b0, BASE + 32'h04, 32'h0, rd, err, lat);
    check("t1 readback", rd, 32'h0);
    bus_idle(1'b0);

    // Reset while a read response is on the bus clears it immediately
    xfer(1'b0, 1'b1, BASE + 32'h00, 32'h1111_2222, rd, err, lat);
    xfer(1'b0, 1'b0, BASE + 32'h00, 32'h0, rd, err, lat);
    check("t1b read_before_reset", rd, 32'h1111_2222);
    hreset = 1'b1;
    #1;
    check_outputs_zero(1'b0, "t1b async_reset");
    drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge hclk);
    hreset = 1'b0;
    xfer(1'b0, 1'b0, BASE + 32'h00, 32'h0, rd, err, lat);
    check("t1b reg_back_to_reset", rd, 32'h0);
    bus_idle(1'b0);

    // Table of back-to-back transfers on the two-wait-state slave
    for (int i = 0; i < 11; i++) begin
      xfer(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err, lat);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd3);
      check($sformatf("vec%0d pslverr", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
      if (!vecs[i].wr || vecs[i].exp_err)
        check($sformatf("vec%0d pr_data", i), rd, vecs[i].exp_rd);
      if (vecs[i].wr && !vecs[i].exp_err)
        model[(vecs[i].addr - BASE) >> 2] = vecs[i].wdata;
    end
    bus_idle(1'b0);

    // Illegal writes must not have touched any register
    for (int i = 0; i < 16; i++) exp_q.push_back(model[i]);
    for (int i = 0; i < 16; i++) begin
      logic [31:0] exp_v;
      xfer(1'b0, 1'b0, BASE + 32'(i * 4), 32'h0, rd, err, lat);
      exp_v = exp_q.pop_front();
      check($sformatf("readback reg%0d", i), rd, exp_v);
      check($sformatf("readback reg%0d pslverr", i), {31'h0, err}, 32'h0);
    end
    bus_idle(1'b0);

    // A different psel bit never gets a response
    @(posedge hclk); #1;
    drive(1'b0, 3'b010, 1'b0, 1'b1, BASE + 32'h0C, 32'hFFFF_FFFF);
    @(posedge hclk); #1;
    drive(1'b0, 3'b010, 1'b1, 1'b1, BASE + 32'h0C, 32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++) begin
      @(negedge hclk);
      check_outputs_zero(1'b0, $sformatf("t4 cyc%0d", i));
    end
    bus_idle(1'b0);
    xfer(1'b0, 1'b0, BASE + 32'h0C, 32'h0, rd, err, lat);
    check("t4 reg_untouched", rd, model[3]);
    bus_idle(1'b0);

    // Drop psel after one wait cycle of a write: abort, no write
    @(posedge hclk); #1;
    drive(1'b0, 3'b001, 1'b0, 1'b1, BASE + 32'h00, 32'h0000_CAFE);
    @(posedge hclk); #1;
    drive(1'b0, 3'b001, 1'b1, 1'b1, BASE + 32'h00, 32'h0000_CAFE);
    @(posedge hclk); #1;
    drive(1'b0, 3'b000, 1'b1, 1'b1, BASE + 32'h00, 32'h0000_CAFE);
    @(negedge hclk);
    sample(1'b0, rdy, err, rd);
    check("t5 pready_t2", {31'h0, rdy}, 32'h0);
    @(negedge hclk);
    check_outputs_zero(1'b0, "t5 after_abort");
    bus_idle(1'b0);
    xfer(1'b0, 1'b0, BASE + 32'h00, 32'h0, rd, err, lat);
    check("t5 read latency", 32'(lat), 32'd3);
    check("t5 reg_untouched", rd, model[0]);
    check("t5 pslverr", {31'h0, err}, 32'h0);
    bus_idle(1'b0);

    // Zero wait states: back-to-back write then read
    xfer(1'b1, 1'b1, BASE + 32'h0C, 32'h1234_5678, rd, err, lat);
    check("t6 write latency", 32'(lat), 32'd1);
    check("t6 write pslverr", {31'h0, err}, 32'h0);
    xfer(1'b1, 1'b0, BASE + 32'h0C, 32'h0, rd, err, lat);
    check("t6 read latency", 32'(lat), 32'd1);
    check("t6 read data", rd, 32'h1234_5678);
    xfer(1'b1, 1'b0, BASE + 32'h40, 32'h0, rd, err, lat);
    check("t6 oob pslverr", {31'h0, err}, 32'h1);
    check("t6 oob pr_data", rd, 32'h0);
    bus_idle(1'b1);
    @(negedge hclk);
    check_outputs_zero(1'b1, "t6 idle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
